// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, column
// strobe pattern, debounce FSM states, frame classification and helpers.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Column 0 strobed, one-cold active-low (same convention as the display AN lines)
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_e;

    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_SINGLE = 2'd1,
        FC_MULTI  = 2'd2
    } frame_class_e;

    // Classification of one complete 16-key frame. code is meaningful only for FC_SINGLE.
    typedef struct packed {
        frame_class_e cls;
        logic [3:0]   code;
    } frame_info_t;

    // Snapshot bit index is {col_idx, row_idx}, so the index of the single set bit
    // is already the key code.
    function automatic frame_info_t classify_frame(input logic [NUM_KEYS-1:0] snap);
        frame_info_t info;
        int unsigned n;
        info.cls  = FC_NONE;
        info.code = 4'h0;
        n         = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                n         = n + 1;
                info.code = i[3:0];
            end
        end
        if (n == 1) begin
            info.cls = FC_SINGLE;
        end else if (n > 1) begin
            info.cls = FC_MULTI;
        end
        return info;
    endfunction

    // Rotate the reset strobe left by the column index: 1110, 1101, 1011, 0111.
    function automatic logic [NUM_COLS-1:0] col_strobe(input logic [1:0] idx);
        logic [2*NUM_COLS-1:0] dbl;
        dbl = {COL_RESET, COL_RESET} << idx;
        return dbl[2*NUM_COLS-1:NUM_COLS];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce for the keypad scanner. Consumes one classification
// per frame and produces the accepted key code, a one-cycle accept pulse and
// a held flag that lasts until a debounced release.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_end,
    input  frame_class_e frame_class,
    input  logic [3:0]   frame_code,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // cnt_q+1 reaching DEBOUNCE is the same as cnt_q sitting at DEBOUNCE-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             accept;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state logic: advances only on a frame boundary
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_class == FC_SINGLE) begin
                        cand_d = frame_code;
                        if (DEBOUNCE == 1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PRESS_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (frame_class == FC_SINGLE && frame_code == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (frame_class == FC_SINGLE) begin
                        // A different lone key restarts the qualification window
                        cand_d = frame_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    // Any key activity keeps us here: no rollover, no auto-repeat
                    if (frame_class == FC_NONE) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (frame_class == FC_NONE) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: pulse and code update on acceptance, held tracks the pressed states
    always_comb begin
        key_valid_d = accept;
        key_code_d  = accept ? cand_d : key_code_q;
        key_held_d  = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns one-cold, synchronises and samples
// the active-low rows at the end of each column dwell, assembles a 16-key frame
// and hands its classification to the debounce FSM once per frame.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [1:0]      COL_LAST   = 2'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic                last_dwell;
    logic                frame_end;
    frame_info_t         frame_info;

    // Two-flop synchroniser; reset to the idle (all released) level so no phantom press appears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Dwell counter and column rotation; frame ends on the last dwell cycle of column 3
    always_comb begin
        last_dwell = (dwell_q == DWELL_LAST);
        dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
        col_idx_d  = last_dwell ? col_idx_q + 1'b1 : col_idx_q;
        frame_end  = last_dwell && (col_idx_q == COL_LAST);
    end

    // Capture the settled rows of the current column; classify the completed frame including
    // the column-3 rows being captured this very cycle
    always_comb begin
        snap_d = snap_q;
        if (last_dwell) begin
            snap_d[{col_idx_q, 2'b00} +: NUM_ROWS] = ~row_sync_q;
        end
        frame_info = classify_frame(snap_d);
    end

    // Scan state registers; reset discards any partial frame and restarts at column 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            col_idx_q <= 2'd0;
            snap_q    <= '0;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
            snap_q    <= snap_d;
        end
    end

    assign col_out = col_strobe(col_idx_q);

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_end   (frame_end),
        .frame_class (frame_info.cls),
        .frame_code  (frame_info.code),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
// A keypad model pulls row r low while column c is strobed and key (c,r) is down.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    always #5 clk = ~clk;

    // Keypad matrix: bit (c*4+r) of pressed means key at column c, row r is down
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_out[c] && pressed[c*4+r]) row_in[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (frame-level view of the keypad behaviour)
    logic       m_held;
    logic [3:0] m_code;
    logic [3:0] m_cand;
    int         m_run;   // consecutive identical single-key frames while not held
    int         m_rel;   // consecutive empty frames while held
    logic       m_acc;   // a key was accepted at the end of the last frame
    int         pulses;

    typedef struct {
        logic [15:0] pat;
        int          nfr;
        int          pulses;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_code = 4'h0;
        m_cand = 4'h0;
        m_run  = 0;
        m_rel  = 0;
        m_acc  = 1'b0;
    endtask

    // Apply the press/release rules to one complete frame of key states
    task automatic model_frame(input logic [15:0] pat);
        int         n;
        logic [3:0] k;
        n = $countones(pat);
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (pat[i]) k = 4'(i);
        m_acc = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_cand) m_run = m_run + 1;
                else begin
                    m_cand = k;
                    m_run  = 1;
                end
                if (m_run == DEBOUNCE) begin
                    m_acc  = 1'b1;
                    m_held = 1'b1;
                    m_code = m_cand;
                    m_run  = 0;
                    m_rel  = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel = m_rel + 1;
                if (m_rel == DEBOUNCE) begin
                    m_held = 1'b0;
                    m_rel  = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    // Run ncyc cycles of a frame with pattern pat, checking every cycle on the negedge.
    // A full frame is folded into the model and its accept pulse counted on the next cycle.
    task automatic run_frame(input logic [15:0] pat, input int ncyc);
        logic [3:0] ecol;
        for (int i = 0; i < ncyc; i++) begin
            if (i == 0) pressed = pat;
            ecol        = 4'hF;
            ecol[i / 4] = 1'b0;
            check("col_out", 16'(col_out), 16'(ecol));
            check("key_valid", 16'(key_valid), (i == 0) ? 16'(m_acc) : 16'h0);
            check("key_held", 16'(key_held), 16'(m_held));
            check("key_code", 16'(key_code), 16'(m_code));
            @(negedge clk);
        end
        if (ncyc == FRAME) begin
            model_frame(pat);
            if (key_valid) pulses++;
        end
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] pat;
        int          r;
        int          p0;

        // Directed records: key pattern, frames to hold it, expected pulses and end state
        tbl[0]  = '{16'h0000, 2, 0, 4'h0, 1'b0};  // idle
        tbl[1]  = '{16'h0200, 2, 0, 4'h0, 1'b0};  // col2,row1 qualifying
        tbl[2]  = '{16'h0200, 1, 1, 4'h9, 1'b1};  // accepted on 3rd frame
        tbl[3]  = '{16'h0200, 3, 0, 4'h9, 1'b1};  // no repeat while held
        tbl[4]  = '{16'h0000, 2, 0, 4'h9, 1'b1};  // release not yet debounced
        tbl[5]  = '{16'h0000, 1, 0, 4'h9, 1'b0};  // released, code kept
        tbl[6]  = '{16'h0008, 2, 0, 4'h9, 1'b0};  // bounce: col0,row3 two frames
        tbl[7]  = '{16'h0000, 1, 0, 4'h9, 1'b0};  // gap
        tbl[8]  = '{16'h0008, 2, 0, 4'h9, 1'b0};
        tbl[9]  = '{16'h0008, 1, 1, 4'h3, 1'b1};  // 3 fresh frames -> accept
        tbl[10] = '{16'h0000, 3, 0, 4'h3, 1'b0};
        tbl[11] = '{16'h0050, 5, 0, 4'h3, 1'b0};  // two keys in col1: rejected
        tbl[12] = '{16'h0040, 2, 0, 4'h3, 1'b0};  // one released, col1,row2 left
        tbl[13] = '{16'h0040, 1, 1, 4'h6, 1'b1};
        tbl[14] = '{16'h0200, 2, 0, 4'h6, 1'b1};  // different key while held ignored
        tbl[15] = '{16'h0000, 3, 0, 4'h6, 1'b0};

        pressed = 16'h0000;
        rst_n   = 1'b0;
        model_reset();
        pulses = 0;
        repeat (3) @(negedge clk);

        check("reset_col_out", 16'(col_out), 16'h000E);
        check("reset_key_code", 16'(key_code), 16'h0);
        check("reset_key_valid", 16'(key_valid), 16'h0);
        check("reset_key_held", 16'(key_held), 16'h0);
        rst_n = 1'b1;

        for (int t = 0; t < 16; t++) begin
            p0 = pulses;
            for (int f = 0; f < tbl[t].nfr; f++) run_frame(tbl[t].pat, FRAME);
            check($sformatf("rec%0d_pulses", t), 16'(pulses - p0), 16'(tbl[t].pulses));
            check($sformatf("rec%0d_code", t), 16'(key_code), 16'(tbl[t].code));
            check($sformatf("rec%0d_held", t), 16'(key_held), 16'(tbl[t].held));
        end

        // Reset in the middle of PRESS_WAIT while column 2 is strobed
        run_frame(16'h0200, FRAME);
        run_frame(16'h0200, 9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("midrst_col_out", 16'(col_out), 16'h000E);
        check("midrst_key_code", 16'(key_code), 16'h0);
        check("midrst_key_held", 16'(key_held), 16'h0);
        p0 = pulses;
        run_frame(16'h0200, FRAME);
        run_frame(16'h0200, FRAME);
        check("midrst_no_early_pulse", 16'(pulses - p0), 16'h0);
        check("midrst_not_held", 16'(key_held), 16'h0);
        run_frame(16'h0200, FRAME);
        check("midrst_pulse", 16'(pulses - p0), 16'h1);
        check("midrst_code", 16'(key_code), 16'h9);
        check("midrst_held", 16'(key_held), 16'h1);
        for (int f = 0; f < 3; f++) run_frame(16'h0000, FRAME);
        check("midrst_released", 16'(key_held), 16'h0);

        // Randomised frames against the model; repeats make debounced presses likely
        prev = 16'h0000;
        for (int f = 0; f < 160; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) pat = prev;
            else if (r < 6) pat = 16'h0000;
            else if (r < 9) pat = 16'h0001 << $urandom_range(0, 15);
            else pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            prev = pat;
            run_frame(pat, FRAME);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
